// File: rtl/lut_config_loader.sv
// Streams CONFIG_WIDTH-bit beats into a MEM_SIZE-bit word and commits it to a LUT
// with a one-cycle comb_set strobe; the committed word is double-buffered.
module lut_config_loader #(
   parameter int unsigned INPUTS       = 4,
   parameter int unsigned MEM_SIZE     = 2**INPUTS,
   parameter int unsigned CONFIG_WIDTH = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_valid,
   input  logic [CONFIG_WIDTH-1:0] cfg_data,
   output logic                    cfg_ready,
   output logic [MEM_SIZE-1:0]     config_out,
   output logic                    comb_set,
   output logic                    done,
   output logic                    loaded
);

   localparam int unsigned BEATS = MEM_SIZE / CONFIG_WIDTH;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      COMMIT = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [MEM_SIZE-1:0] shift, shift_nxt;
   logic [MEM_SIZE-1:0] config_nxt;
   logic [MEM_SIZE-1:0] word_c;
   logic                ready_nxt, comb_set_nxt, done_nxt, loaded_nxt;

   // Shift the new beat into the LSBs; earlier beats move toward the MSBs.
   assign word_c = MEM_SIZE'({shift, cfg_data});

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD;
         cnt        <= '0;
         shift      <= '0;
         config_out <= '0;
         cfg_ready  <= 1'b1;
         comb_set   <= 1'b0;
         done       <= 1'b0;
         loaded     <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         shift      <= shift_nxt;
         config_out <= config_nxt;
         cfg_ready  <= ready_nxt;
         comb_set   <= comb_set_nxt;
         done       <= done_nxt;
         loaded     <= loaded_nxt;
      end
   end

   // Next state; outputs are decoded from the next state so they stay registered.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      shift_nxt  = shift;
      config_nxt = config_out;

      unique case (state)
         LOAD: begin
            if (cfg_valid) begin
               shift_nxt = word_c;
               if (cnt == CNT_W'(BEATS - 1)) begin
                  cnt_nxt    = '0;
                  config_nxt = word_c;
                  state_nxt  = COMMIT;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         COMMIT:  state_nxt = SETTLE;
         SETTLE:  state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase

      ready_nxt    = (state_nxt == LOAD);
      comb_set_nxt = (state_nxt == COMMIT);
      done_nxt     = (state_nxt == SETTLE);
      loaded_nxt   = loaded | (state_nxt == SETTLE);
   end

endmodule

// File: tb/tb_lut_config_loader.sv
// Scoreboarded bench for lut_config_loader: 1-bit and 4-bit beat instances plus a LUT model.
module tb_lut_config_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v1 = 1'b0;
   logic [0:0]  d1 = 1'b0;
   logic        v4 = 1'b0;
   logic [3:0]  d4 = 4'h0;
   logic        ready1, comb_set1, done1, loaded1;
   logic        ready4, comb_set4, done4, loaded4;
   logic [15:0] config_out1, config_out4;
   logic [15:0] lut_mem = 16'h0;

   int total = 0;
   int bad   = 0;
   logic [15:0] q1[$];
   logic [15:0] q4[$];
   logic prev1 = 1'b0;
   logic prev4 = 1'b0;

   always #5 clk = ~clk;

   lut_config_loader #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .cfg_valid(v1), .cfg_data(d1), .cfg_ready(ready1),
      .config_out(config_out1), .comb_set(comb_set1), .done(done1), .loaded(loaded1)
   );

   lut_config_loader #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .cfg_valid(v4), .cfg_data(d4), .cfg_ready(ready4),
      .config_out(config_out4), .comb_set(comb_set4), .done(done4), .loaded(loaded4)
   );

   // LUT model: latches the word on comb_set, retains it through loader resets.
   always @(posedge clk) if (comb_set1) lut_mem <= config_out1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every commit pops the scoreboard; done must follow comb_set by one cycle.
   always @(negedge clk) begin
      if (rst) begin
         prev1 <= 1'b0;
         prev4 <= 1'b0;
      end else begin
         if (comb_set1 === 1'b1) begin
            if (q1.size() == 0) chk("unexpected_commit1", 32'(config_out1), 32'hFFFF_FFFF);
            else chk("commit1", 32'(config_out1), 32'(q1.pop_front()));
         end
         if (comb_set4 === 1'b1) begin
            if (q4.size() == 0) chk("unexpected_commit4", 32'(config_out4), 32'hFFFF_FFFF);
            else chk("commit4", 32'(config_out4), 32'(q4.pop_front()));
         end
         chk("done1_after_strobe", 32'(done1), 32'(prev1));
         chk("done4_after_strobe", 32'(done4), 32'(prev4));
         prev1 <= comb_set1;
         prev4 <= comb_set4;
      end
   end

   // One beat on dut1; called and returns #1 after a rising edge.
   task automatic beat1(input logic b);
      logic acc;
      int   n;
      n   = 0;
      acc = 1'b0;
      v1  = 1'b1;
      d1  = b;
      while (!acc && n < 50) begin
         @(negedge clk) acc = ready1;
         @(posedge clk) #1;
         n++;
      end
      if (!acc) chk("beat1_timeout", 32'(acc), 32'd1);
      v1 = 1'b0;
   endtask

   task automatic beat4(input logic [3:0] nib);
      logic acc;
      int   n;
      n   = 0;
      acc = 1'b0;
      v4  = 1'b1;
      d4  = nib;
      while (!acc && n < 50) begin
         @(negedge clk) acc = ready4;
         @(posedge clk) #1;
         n++;
      end
      if (!acc) chk("beat4_timeout", 32'(acc), 32'd1);
   endtask

   task automatic stream1(input logic [15:0] w);
      q1.push_back(w);
      for (int i = 15; i >= 0; i--) beat1(w[i]);
   endtask

   task automatic stream4(input logic [15:0] w, input bit gaps);
      q4.push_back(w);
      for (int i = 3; i >= 0; i--) begin
         if (gaps) begin
            v4 = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         beat4(w[i*4 +: 4]);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] addr;

      // Reset values
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_config_out", 32'(config_out1), 32'h0);
      chk("rst_comb_set", 32'(comb_set1), 32'h0);
      chk("rst_done", 32'(done1), 32'h0);
      chk("rst_loaded", 32'(loaded1), 32'h0);
      chk("rst_ready", 32'(ready1), 32'h1);
      idle(1);

      // Back-to-back stream with exact commit timing
      stream1(16'hA5C3);
      @(negedge clk);
      chk("k1_comb_set", 32'(comb_set1), 32'h1);
      chk("k1_config_out", 32'(config_out1), 32'hA5C3);
      chk("k1_ready", 32'(ready1), 32'h0);
      @(negedge clk);
      chk("k2_done", 32'(done1), 32'h1);
      chk("k2_comb_set", 32'(comb_set1), 32'h0);
      chk("k2_loaded", 32'(loaded1), 32'h1);
      chk("k2_ready", 32'(ready1), 32'h0);
      @(negedge clk);
      chk("k3_ready", 32'(ready1), 32'h1);
      chk("k3_done", 32'(done1), 32'h0);
      idle(1);

      // Double buffering: partial stream must not disturb the committed word
      stream1(16'hFFFF);
      idle(3);
      for (int i = 0; i < 8; i++) begin
         beat1(1'b0);
         @(negedge clk);
         chk("dbuf_config_out", 32'(config_out1), 32'hFFFF);
         chk("dbuf_comb_set", 32'(comb_set1), 32'h0);
         @(posedge clk) #1;
      end

      // Mid-stream reset after beat 9
      beat1(1'b0);
      rst = 1'b1;
      @(posedge clk) #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_config_out", 32'(config_out1), 32'h0);
      chk("midrst_loaded", 32'(loaded1), 32'h0);
      chk("midrst_ready", 32'(ready1), 32'h1);
      @(posedge clk) #1;
      stream1(16'h8001);
      idle(3);
      chk("after_rst_word", 32'(config_out1), 32'h8001);

      // 4-bit beats with gaps, then a second word with valid held through COMMIT/SETTLE
      stream4(16'h1234, 1'b1);
      stream4(16'hBEEF, 1'b0);
      v4 = 1'b0;
      idle(3);
      chk("w4_final_word", 32'(config_out4), 32'hBEEF);
      chk("w4_loaded", 32'(loaded4), 32'h1);

      // End-to-end: XOR truth table gives parity of the address
      stream1(16'h6996);
      idle(4);
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         chk("lut_parity", 32'(lut_mem[addr]), 32'(^addr));
      end

      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q4_drained", 32'(q4.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lut_config_loader.md
# lut_config_loader

Writer side of the LUT configuration interface. The block accepts a streamed bitstream in CONFIG_WIDTH-bit beats over a valid/ready handshake and assembles a MEM_SIZE-bit configuration word. It then drives that word onto a LUT's `config_in` with a one-cycle `comb_set` commit strobe. The committed word is double-buffered, so streaming the next word never disturbs the latched configuration.

## Interface
Parameters:
- INPUTS, 4, LUT address width.
- MEM_SIZE, 2**INPUTS, configuration word width in bits.
- CONFIG_WIDTH, 1, bits per input beat. MEM_SIZE must be a multiple of CONFIG_WIDTH.

Ports:
- clk  input  1  single clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  beat valid.
- cfg_data  input  CONFIG_WIDTH  beat payload.
- cfg_ready  output  1  beat accepted when `cfg_valid && cfg_ready` at a rising edge.
- config_out  output  MEM_SIZE  connects to the LUT `config_in`.
- comb_set  output  1  connects to the LUT `comb_set` (commit strobe).
- done  output  1  one-cycle pulse after each commit.
- loaded  output  1  sticky; set after the first commit and cleared only by `rst`.

## Operation
- BEATS = MEM_SIZE/CONFIG_WIDTH. The beat counter is $clog2(BEATS) bits wide, with a minimum of 1.
- State machine states: LOAD, COMMIT, SETTLE.
- **LOAD**
  - `cfg_ready`=1, `comb_set`=0.
  - On each accepted beat: `shift <= {shift[MEM_SIZE-CONFIG_WIDTH-1:0], cfg_data}`, then increment the counter.
  - The first beat ends up in the MSBs and the last beat in the LSBs.
  - Accepting beat BEATS-1 (counter == BEATS-1): `config_out <= {shift[...], cfg_data}` (the complete word), counter <= 0, and the state moves to COMMIT.
  - With `cfg_valid`=0 the block holds all state; idle gaps between beats are legal.
- **COMMIT**
  - `comb_set`=1 and `cfg_ready`=0; inputs are ignored.
  - Always moves to SETTLE next cycle.
- **SETTLE**
  - `comb_set`=0 and `cfg_ready`=0.
  - `config_out` is held, giving the latches one cycle of hold margin.
  - `done`=1 for this cycle only; `loaded` <= 1.
  - Always moves to LOAD next cycle.
- `config_out` changes only on the edge entering COMMIT. It is stable for the whole cycle in which `comb_set`=1 and remains stable until the next commit.
- The `shift` register is internal only; partial words are never visible on `config_out`.
- Reset: state=LOAD, counter=0, shift=0, `config_out`=0, `comb_set`=0, `done`=0, `loaded`=0, and `cfg_ready`=1 in the first cycle after reset.
- Reset mid-stream discards the partial word.
- Reset during COMMIT or SETTLE drops the strobe/done in the next cycle and clears `config_out` to 0. The LUT retains whatever it already latched.
- Outputs `comb_set`, `done` and `cfg_ready` are decoded from state registers with no combinational path from `cfg_valid`/`cfg_data`.

## Timing
- Final beat accepted at edge k:
  - cycle after k: COMMIT, `comb_set`=1, `config_out` = new word.
  - after edge k+1: SETTLE, `done`=1.
  - after edge k+2: LOAD, `cfg_ready`=1.
- Minimum period per word: BEATS+2 cycles (18 for defaults).
- Beat acceptance requires both `cfg_valid` and `cfg_ready` sampled high at the same edge. A beat offered while `cfg_ready`=0 is not consumed; the source must hold it.
- `rst` has priority over every other event at the same edge.

## Test plan
- **Reset values:** assert `rst` for 2 cycles -> `config_out`=16'h0000, `comb_set`=0, `done`=0, `loaded`=0, `cfg_ready`=1.
- **Back-to-back stream, defaults:** stream 16'hA5C3 MSB-first with `cfg_valid` held high -> after beat 16, one cycle of `comb_set`=1 with `config_out`=16'hA5C3, then `done`=1 with `comb_set`=0, `loaded`=1, and `cfg_ready` returns 2 cycles after the last beat.
- **Gappy stream, CONFIG_WIDTH=4:** send nibbles 4'h1,4'h2,4'h3,4'h4 with random idle gaps -> exactly one commit with `config_out`=16'h1234. `cfg_valid` high during COMMIT/SETTLE consumes nothing, and the next word 16'hBEEF commits correctly.
- **Double-buffering:** after committing 16'hFFFF, stream 8 beats of 16'h0000 -> `config_out` stays 16'hFFFF and `comb_set` stays 0 throughout.
- **Mid-stream reset:** reset after beat 9 -> counter=0 and `config_out`=0. A following full stream of 16'h8001 commits 16'h8001, with no stale bits from the aborted word.
- **End-to-end with LUT:** connect to a LUT and commit the XOR truth table 16'h6996 -> the LUT output equals the parity of `addr` for all 16 addresses.
